// File: rtl/muldiv_unit_32.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock, result and rd back to the register file.
// Optional macro MULDIV_FASTPATH_EN lets zero-operand, divide-by-zero and signed-overflow ops skip the iterations.
module muldiv_unit_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [4:0]       rdIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rdOut,
  output logic             writeEn
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | WIDTH shift-add / shift-subtract iterations
  // FIX   | phase 0: sign correction, phase 1: result select and register
  // DONE  | done pulse, busy still high
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             fix_ph;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             neg_hi;
  logic             neg_lo;
  logic             div0_q;
  logic             ovf_q;
  logic             zero_q;
  logic [4:0]       rd_q;

  logic             is_div_in;
  logic             sgn_a_in;
  logic             sgn_b_in;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             div0_in;
  logic             ovf_in;
  logic             zero_in;
  logic             fast_in;
  logic             accept;

  logic [WIDTH:0]     mul_sum;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   res_sel;

  assign is_div_in = op[2];
  assign sgn_a_in  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign sgn_b_in  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg_in  = sgn_a_in & dataA[WIDTH-1];
  assign b_neg_in  = sgn_b_in & dataB[WIDTH-1];
  assign mag_a_in  = a_neg_in ? -dataA : dataA;
  assign mag_b_in  = b_neg_in ? -dataB : dataB;
  assign div0_in   = is_div_in && (dataB == '0);
  assign ovf_in    = ((op == OP_DIV) || (op == OP_REM)) && (dataA == MIN_NEG) && (dataB == '1);
  assign zero_in   = (dataA == '0) || (!is_div_in && (dataB == '0));

`ifdef MULDIV_FASTPATH_EN
  assign fast_in = div0_in | ovf_in | zero_in;
`else
  assign fast_in = 1'b0;
`endif

  assign accept = start && (state == IDLE);

  // Multiply: lo holds the multiplier, shifted out LSB-first as the product shifts in.
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_q} : '0);
  // Divide: {hi,lo} shifts left; only the low WIDTH bits of the difference are ever kept.
  assign div_ge   = {hi, lo[WIDTH-1]} >= {1'b0, mag_q};
  assign div_sub  = {hi[WIDTH-2:0], lo[WIDTH-1]} - mag_q;
  assign prod_neg = -{hi, lo};

  // Boundary overrides take precedence so the fast path and iterative path agree bit for bit.
  always_comb begin
    res_sel = '0;
    if (div0_q) begin
      res_sel = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      res_sel = op_q[1] ? '0 : MIN_NEG;
    end else if (zero_q) begin
      res_sel = '0;
    end else if (op_q[2]) begin
      res_sel = op_q[1] ? hi : lo;
    end else begin
      res_sel = (op_q == OP_MUL) ? lo : hi;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    writeEn   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = fast_in ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      end
      FIX: begin
        busy = 1'b1;
        if (fix_ph) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        writeEn   = (rd_q != 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdOut = rd_q;

  always_ff @(posedge clk) begin
    if (r) begin
      state  <= IDLE;
      cnt    <= '0;
      fix_ph <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      mag_q  <= '0;
      hi     <= '0;
      lo     <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      rd_q   <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op;
        a_q    <= dataA;
        rd_q   <= rdIn;
        cnt    <= '0;
        fix_ph <= 1'b0;
        hi     <= '0;
        div0_q <= div0_in;
        ovf_q  <= ovf_in;
        zero_q <= zero_in;
        if (is_div_in) begin
          lo     <= mag_a_in;
          mag_q  <= mag_b_in;
          neg_lo <= a_neg_in ^ b_neg_in;
          neg_hi <= a_neg_in;
        end else begin
          lo     <= mag_b_in;
          mag_q  <= mag_a_in;
          neg_lo <= a_neg_in ^ b_neg_in;
          neg_hi <= a_neg_in ^ b_neg_in;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (op_q[2]) begin
          hi <= div_ge ? div_sub : {hi[WIDTH-2:0], lo[WIDTH-1]};
          lo <= {lo[WIDTH-2:0], div_ge};
        end else begin
          hi <= mul_sum[WIDTH:1];
          lo <= {mul_sum[0], lo[WIDTH-1:1]};
        end
      end else if (state == FIX) begin
        fix_ph <= 1'b1;
        if (!fix_ph) begin
          if (op_q[2]) begin
            if (neg_hi) hi <= -hi;
            if (neg_lo) lo <= -lo;
          end else if (neg_lo) begin
            {hi, lo} <= prod_neg;
          end
        end else begin
          result <= res_sel;
        end
      end
    end
  end

endmodule
